// File: rtl/pb_debounce_if.sv
// Pushbutton conditioner signal bundle.
// master: the side driving the raw pins and consuming the clean outputs.
// slave:  the debouncer itself.
interface pb_debounce_if;
    logic pb_raw;
    logic sel_raw;
    logic pb_n;
    logic press_pulse;
    logic release_pulse;
    logic select;

    modport master (
        output pb_raw,
        output sel_raw,
        input  pb_n,
        input  press_pulse,
        input  release_pulse,
        input  select
    );

    modport slave (
        input  pb_raw,
        input  sel_raw,
        output pb_n,
        output press_pulse,
        output release_pulse,
        output select
    );
endinterface

// File: rtl/pb_debounce.sv
// pb_debounce: synchronises a raw pushbutton and up/down slide switch and
// debounces the button with a stability counter and a four-state FSM.
// pb_n is a clean active-low level whose falling edge marks one accepted press.
//
// Optional build macro PB_DEBOUNCE_AUTO_REPEAT_EN: while the button stays
// accepted as pressed, issue an extra press (pulse plus a one-cycle high blip
// on pb_n) after HOLD_CYCLES, then every REPEAT_CYCLES.
//
// state        | meaning
// IDLE         | released, waiting for a press
// PRESS_WAIT   | press seen, qualifying stability
// PRESSED      | press accepted, pb_n low
// RELEASE_WAIT | release seen, qualifying stability (pb_n still low)
module pb_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic          clk,
    input  logic          rst,
    pb_debounce_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Raw pin level that means "released"; the synchroniser resets to it so
    // reset never looks like a press.
    localparam logic PB_IDLE_LVL = ACTIVE_LOW;

    logic             pb_s1_q, pb_s2_q;
    logic             sel_s1_q, sel_s2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             pb_n_q, pb_n_d;
    logic             pressed_s;
    logic             rpt_fire;

    assign pressed_s = pb_s2_q ^ ACTIVE_LOW;

`ifdef PB_DEBOUNCE_AUTO_REPEAT_EN
    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] HOLD_LAST   = RPT_W'(HOLD_CYCLES - 1);
    localparam logic [RPT_W-1:0] REPEAT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_armed_q, rpt_armed_d;

    // Fire when the held time reaches the initial hold, then each repeat period.
    always_comb begin
        rpt_fire = (state_q == PRESSED) && pressed_s &&
                   (rpt_q == (rpt_armed_q ? REPEAT_LAST : HOLD_LAST));
    end

    // Repeat counter: runs while held in PRESSED, freezes in RELEASE_WAIT,
    // clears once the FSM leaves the pressed pair of states.
    always_comb begin
        rpt_d       = rpt_q;
        rpt_armed_d = rpt_armed_q;
        if (state_q == PRESSED && pressed_s) begin
            if (rpt_fire) begin
                rpt_d       = '0;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end else if (state_d != PRESSED && state_d != RELEASE_WAIT) begin
            rpt_d       = '0;
            rpt_armed_d = 1'b0;
        end
    end

    // Repeat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Next-state, stability counter and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (rpt_fire) begin
                    press_d = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // The repeat blip lifts pb_n for one cycle so the next stage sees a new falling edge.
        pb_n_d = !(state_d == PRESSED || state_d == RELEASE_WAIT) || rpt_fire;
    end

    // Synchronisers, FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_s1_q   <= PB_IDLE_LVL;
            pb_s2_q   <= PB_IDLE_LVL;
            sel_s1_q  <= 1'b0;
            sel_s2_q  <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            pb_n_q    <= 1'b1;
        end else begin
            pb_s1_q   <= bus.pb_raw;
            pb_s2_q   <= pb_s1_q;
            sel_s1_q  <= bus.sel_raw;
            sel_s2_q  <= sel_s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            pb_n_q    <= pb_n_d;
        end
    end

    assign bus.pb_n          = pb_n_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.select        = sel_s2_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Self-checking bench for pb_debounce: directed steps plus random button
// activity, compared every cycle against a run-length reference model.
module tb_pb_debounce;
    localparam int D    = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
    localparam bit AL   = 1'b1;

`ifdef PB_DEBOUNCE_AUTO_REPEAT_EN
    localparam int EXP_EXTRA = 5;
`else
    localparam int EXP_EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pb_debounce_if bus ();

    pb_debounce #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (8),
        .ACTIVE_LOW      (AL),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: accepted level flips once the synchronised pressed
    // level has disagreed with it for D+1 consecutive edges.
    bit pb_hist[$];
    bit sel_hist[$];
    bit acc;
    int run;
    int held;
    bit m_pb_n, m_press, m_rel, m_sel;

    int fall_cnt, rise_cnt;
    bit prev_pb_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pb_hist  = '{AL, AL};
        sel_hist = '{1'b0};
        acc = 1'b0; run = 0; held = 0;
        m_pb_n = 1'b1; m_press = 1'b0; m_rel = 1'b0; m_sel = 1'b0;
        prev_pb_n = 1'b1;
    endtask

    task automatic model_edge(input bit pb, input bit sel);
        bit ps;
        bit rep;
        ps = pb_hist.pop_front() ^ AL;
        pb_hist.push_back(pb);
        m_sel = sel_hist.pop_front();
        sel_hist.push_back(sel);
        m_press = 1'b0; m_rel = 1'b0; rep = 1'b0;
        if (acc && run == 0 && ps) begin
            held++;
`ifdef PB_DEBOUNCE_AUTO_REPEAT_EN
            if (held == HOLD || (held > HOLD && (held - HOLD) % REP == 0)) rep = 1'b1;
`endif
        end
        if (ps != acc) run++;
        else run = 0;
        if (run == D + 1) begin
            acc = ps;
            run = 0;
            if (acc) m_press = 1'b1;
            else begin
                m_rel = 1'b1;
                held = 0;
            end
        end
        if (rep) m_press = 1'b1;
        m_pb_n = !acc || rep;
    endtask

    // One clock: drive, let the edge happen, update model, compare at negedge.
    task automatic step(input bit pb, input bit sel);
        bus.pb_raw  = pb;
        bus.sel_raw = sel;
        @(posedge clk);
        model_edge(pb, sel);
        @(negedge clk);
        chk("pb_n", bus.pb_n, m_pb_n);
        chk("press_pulse", bus.press_pulse, m_press);
        chk("release_pulse", bus.release_pulse, m_rel);
        chk("select", bus.select, m_sel);
        chk("pulse_exclusive", bus.press_pulse & bus.release_pulse, 0);
        if (prev_pb_n && !bus.pb_n) fall_cnt++;
        if (!prev_pb_n && bus.pb_n) rise_cnt++;
        prev_pb_n = bus.pb_n;
    endtask

    task automatic run_level(input bit pb, input bit sel, input int n,
                             output int fp, output int fr, output int np, output int nr);
        fp = -1; fr = -1; np = 0; nr = 0;
        for (int i = 0; i < n; i++) begin
            step(pb, sel);
            if (bus.press_pulse === 1'b1) begin
                np++;
                if (fp < 0) fp = i;
            end
            if (bus.release_pulse === 1'b1) begin
                nr++;
                if (fr < 0) fr = i;
            end
        end
    endtask

    initial begin
        int fp, fr, np, nr;
        int tp, tr;
        bit lvl;
        int len;
        bit sel_lvl;
        int f0, r0;

        fall_cnt = 0; rise_cnt = 0;
        bus.pb_raw  = 1'b1;
        bus.sel_raw = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_pb_n", bus.pb_n, 1);
        chk("rst_press", bus.press_pulse, 0);
        chk("rst_release", bus.release_pulse, 0);
        chk("rst_select", bus.select, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Clean press held 20 cycles.
        run_level(1'b0, 1'b0, 20, fp, fr, np, nr);
        chk("press_latency", fp, 6);
        chk("press_count", np, 1 + ((20 - 7 > HOLD) ? 1 : 0) * 0);
        chk("press_pb_n_low", bus.pb_n, 0);

        // Release held 10 cycles.
        run_level(1'b1, 1'b0, 10, fp, fr, np, nr);
        chk("release_latency", fr, 6);
        chk("release_pb_n_high", bus.pb_n, 1);

        // Bounce: short glitches then settle released.
        tp = 0; tr = 0;
        for (int k = 0; k < 4; k++) begin
            run_level((k % 2) == 1, 1'b0, $urandom_range(1, 3), fp, fr, np, nr);
            tp += np; tr += nr;
        end
        run_level(1'b1, 1'b0, 10, fp, fr, np, nr);
        tp += np; tr += nr;
        chk("bounce_no_press", tp, 0);
        chk("bounce_no_release", tr, 0);
        chk("bounce_pb_n", bus.pb_n, 1);

        // Second press; downstream counter sees two falling edges in total.
        run_level(1'b0, 1'b0, 10, fp, fr, np, nr);
        chk("second_press_latency", fp, 6);
        chk("falling_edges", fall_cnt, 2);
        run_level(1'b1, 1'b0, 10, fp, fr, np, nr);

        // Select synchroniser latency.
        step(1'b1, 1'b1);
        chk("select_edge0", bus.select, 0);
        step(1'b1, 1'b1);
        chk("select_edge1", bus.select, 1);

        // Asynchronous reset while the button is held, then re-qualification.
        run_level(1'b0, 1'b1, 8, fp, fr, np, nr);
        chk("pre_reset_pb_n", bus.pb_n, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pb_n", bus.pb_n, 1);
        chk("async_rst_press", bus.press_pulse, 0);
        chk("async_rst_release", bus.release_pulse, 0);
        chk("async_rst_select", bus.select, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run_level(1'b0, 1'b1, 12, fp, fr, np, nr);
        chk("requalify_latency", fp, 6);
        run_level(1'b1, 1'b1, 10, fp, fr, np, nr);

        // Random button and switch activity against the model.
        lvl = 1'b1;
        sel_lvl = 1'b1;
        for (int k = 0; k < 60; k++) begin
            lvl = ~lvl;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 6);
            if ($urandom_range(0, 4) == 0) sel_lvl = ~sel_lvl;
            run_level(lvl, sel_lvl, len, fp, fr, np, nr);
        end
        run_level(1'b1, 1'b0, 12, fp, fr, np, nr);
        chk("random_settle_pb_n", bus.pb_n, 1);

        // Long hold: auto-repeat presses only when the feature is built in.
        f0 = fall_cnt; r0 = rise_cnt;
        run_level(1'b0, 1'b0, 66, fp, fr, np, nr);
        chk("hold_first_press", fp, 6);
        chk("hold_extra_presses", np - 1, EXP_EXTRA);
        chk("hold_pb_n_blips", rise_cnt - r0, EXP_EXTRA);
        chk("hold_falling_edges", fall_cnt - f0, 1 + EXP_EXTRA);
        run_level(1'b1, 1'b0, 10, fp, fr, np, nr);
        chk("hold_release", fr, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout: simulation did not finish");
    end
endmodule
